// File: rtl/imm_branch_pkg.sv
// Shared opcodes, condition codes and flag layout for the immediate/branch execute unit.
package imm_branch_pkg;

  localparam logic [2:0] OP_LI   = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SUBI = 3'b010;
  localparam logic [2:0] OP_B    = 3'b100;
  localparam logic [2:0] OP_BCC  = 3'b111;

  localparam logic [2:0] CC_BE  = 3'b000;
  localparam logic [2:0] CC_BLT = 3'b001;
  localparam logic [2:0] CC_BLE = 3'b010;
  localparam logic [2:0] CC_BNE = 3'b011;

  localparam int FLAG_S = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef struct packed {
    logic s;
    logic v;
    logic z;
    logic c;
  } flags_t;

  function automatic logic cond_met(input logic [2:0] cond, input flags_t f);
    logic w_met;
    case (cond)
      CC_BE:   w_met = f.z;
      CC_BLT:  w_met = f.s ^ f.v;
      CC_BLE:  w_met = f.z | (f.s ^ f.v);
      CC_BNE:  w_met = ~f.z;
      default: w_met = 1'b0;
    endcase
    return w_met;
  endfunction

endpackage

// File: rtl/imm_branch_alu.sv
// Combinational datapath: immediate arithmetic, flag generation and PC-relative target.
module imm_branch_alu
  import imm_branch_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DISP_W = 8
) (
  input  logic [2:0]        i_op,
  input  logic [WIDTH-1:0]  i_pc,
  input  logic [WIDTH-1:0]  i_rb,
  input  logic [DISP_W-1:0] i_disp,
  output logic [WIDTH-1:0]  o_result,
  output flags_t            o_flags,
  output logic              o_rd_we,
  output logic              o_flags_we,
  output logic              o_is_b,
  output logic              o_is_bcc
);

  logic [WIDTH-1:0] w_d;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_target;

  assign w_d      = {{(WIDTH-DISP_W){i_disp[DISP_W-1]}}, i_disp};
  assign w_sum    = {1'b0, i_rb} + {1'b0, w_d};
  // The extra top bit of the subtraction is the unsigned borrow.
  assign w_diff   = {1'b0, i_rb} - {1'b0, w_d};
  assign w_target = i_pc + w_d + {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    o_result   = '0;
    o_flags    = '0;
    o_rd_we    = 1'b0;
    o_flags_we = 1'b0;
    o_is_b     = 1'b0;
    o_is_bcc   = 1'b0;
    case (i_op)
      OP_LI: begin
        o_result   = w_d;
        o_rd_we    = 1'b1;
        o_flags_we = 1'b1;
      end
      OP_ADDI: begin
        o_result   = w_sum[WIDTH-1:0];
        o_flags.c  = w_sum[WIDTH];
        o_flags.v  = (i_rb[WIDTH-1] == w_d[WIDTH-1]) & (w_sum[WIDTH-1] != i_rb[WIDTH-1]);
        o_rd_we    = 1'b1;
        o_flags_we = 1'b1;
      end
      OP_SUBI: begin
        o_result   = w_diff[WIDTH-1:0];
        o_flags.c  = w_diff[WIDTH];
        o_flags.v  = (i_rb[WIDTH-1] != w_d[WIDTH-1]) & (w_diff[WIDTH-1] != i_rb[WIDTH-1]);
        o_rd_we    = 1'b1;
        o_flags_we = 1'b1;
      end
      OP_B: begin
        o_result = w_target;
        o_is_b   = 1'b1;
      end
      OP_BCC: begin
        o_result = w_target;
        o_is_bcc = 1'b1;
      end
      default: begin
        o_result = '0;
      end
    endcase
    if (o_flags_we) begin
      o_flags.s = o_result[WIDTH-1];
      o_flags.z = (o_result == '0);
    end else begin
      o_flags.s = 1'b0;
      o_flags.z = 1'b0;
    end
  end

endmodule

// File: rtl/imm_branch_unit.sv
// Registered immediate/branch execute stage with flag register and valid/ready output.
// Define IMM_BRANCH_FLAG_BYPASS_EN to let BCC read stalled, uncommitted flags without interlock.
module imm_branch_unit
  import imm_branch_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DISP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [2:0]        in_cond,
  input  logic [WIDTH-1:0]  in_pc,
  input  logic [WIDTH-1:0]  in_rb,
  input  logic [DISP_W-1:0] in_disp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic              out_rd_we,
  output logic              out_flags_we,
  output logic [3:0]        out_flags,
  output logic              out_br_taken,
  output logic [3:0]        flags_q
);

  logic [WIDTH-1:0] w_result;
  flags_t           w_flags;
  logic             w_rd_we;
  logic             w_flags_we;
  logic             w_is_b;
  logic             w_is_bcc;
  flags_t           w_src_flags;
  logic             w_taken;
  logic             w_hazard;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_commit;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_rd_we;
  logic             r_out_flags_we;
  flags_t           r_out_flags;
  logic             r_out_br_taken;
  flags_t           r_flags_q;

  imm_branch_alu #(
    .WIDTH  (WIDTH),
    .DISP_W (DISP_W)
  ) u_alu (
    .i_op       (in_op),
    .i_pc       (in_pc),
    .i_rb       (in_rb),
    .i_disp     (in_disp),
    .o_result   (w_result),
    .o_flags    (w_flags),
    .o_rd_we    (w_rd_we),
    .o_flags_we (w_flags_we),
    .o_is_b     (w_is_b),
    .o_is_bcc   (w_is_bcc)
  );

  // Pending entry's flags are the ones that will be committed if it leaves this cycle.
  assign w_src_flags = (r_out_valid & r_out_flags_we) ? r_out_flags : r_flags_q;
  assign w_taken     = w_is_b | (w_is_bcc & cond_met(in_cond, w_src_flags));

`ifdef IMM_BRANCH_FLAG_BYPASS_EN
  assign w_hazard = 1'b0;
`else
  assign w_hazard = (in_op == OP_BCC) & r_out_valid & r_out_flags_we & ~out_ready;
`endif

  assign in_ready   = ~flush & (~r_out_valid | out_ready) & ~w_hazard;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_commit   = w_out_fire & r_out_flags_we & ~flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_out_result   <= '0;
      r_out_rd_we    <= 1'b0;
      r_out_flags_we <= 1'b0;
      r_out_flags    <= '0;
      r_out_br_taken <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_out_valid    <= 1'b1;
      r_out_result   <= w_result;
      r_out_rd_we    <= w_rd_we;
      r_out_flags_we <= w_flags_we;
      r_out_flags    <= w_flags;
      r_out_br_taken <= w_taken;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flags_q <= '0;
    end else if (w_commit) begin
      r_flags_q <= r_out_flags;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_result   = r_out_result;
  assign out_rd_we    = r_out_rd_we;
  assign out_flags_we = r_out_flags_we;
  assign out_flags    = r_out_flags;
  assign out_br_taken = r_out_br_taken;
  assign flags_q      = r_flags_q;

endmodule

// File: tb/tb_imm_branch_unit.sv
// Self-checking bench for imm_branch_unit: arithmetic reference model plus directed literal checks.
module tb_imm_branch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_cond;
  logic [15:0] in_pc;
  logic [15:0] in_rb;
  logic [7:0]  in_disp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_rd_we;
  logic        out_flags_we;
  logic [3:0]  out_flags;
  logic        out_br_taken;
  logic [3:0]  flags_q;

  int n_tests = 0;
  int n_fail  = 0;

  imm_branch_unit #(.WIDTH(16), .DISP_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_cond      (in_cond),
    .in_pc        (in_pc),
    .in_rb        (in_rb),
    .in_disp      (in_disp),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd_we    (out_rd_we),
    .out_flags_we (out_flags_we),
    .out_flags    (out_flags),
    .out_br_taken (out_br_taken),
    .flags_q      (flags_q)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  fl;
    logic        rd;
    logic        fw;
    logic        tk;
  } mres_t;

  logic       m_valid;
  mres_t      m_pay;
  logic [3:0] m_flags_q;

  // Reference semantics in plain integer arithmetic; flags are {S,V,Z,C}.
  function automatic mres_t mexec(input logic [2:0] op, input logic [2:0] cond, input logic [15:0] pc,
                                  input logic [15:0] rb, input logic [7:0] disp, input logic [3:0] sf);
    mres_t       r;
    int          d;
    int          rbs;
    int          u;
    int          s;
    logic [31:0] t;
    r   = '0;
    d   = int'($signed(disp));
    rbs = int'($signed(rb));
    case (op)
      3'b000: begin
        t = d; r.res = t[15:0]; r.rd = 1'b1; r.fw = 1'b1;
        r.fl = {r.res[15], 1'b0, (r.res == 16'h0), 1'b0};
      end
      3'b001: begin
        u = int'(rb) + (d & 32'hFFFF); s = rbs + d; t = u; r.res = t[15:0];
        r.rd = 1'b1; r.fw = 1'b1;
        r.fl = {r.res[15], (s > 32767 || s < -32768), (r.res == 16'h0), (u > 65535)};
      end
      3'b010: begin
        u = int'(rb) - (d & 32'hFFFF); s = rbs - d; t = u; r.res = t[15:0];
        r.rd = 1'b1; r.fw = 1'b1;
        r.fl = {r.res[15], (s > 32767 || s < -32768), (r.res == 16'h0), (u < 0)};
      end
      3'b100: begin
        t = int'(pc) + 1 + d; r.res = t[15:0]; r.tk = 1'b1;
      end
      3'b111: begin
        t = int'(pc) + 1 + d; r.res = t[15:0];
        case (cond)
          3'b000:  r.tk = sf[1];
          3'b001:  r.tk = sf[3] != sf[2];
          3'b010:  r.tk = sf[1] || (sf[3] != sf[2]);
          3'b011:  r.tk = !sf[1];
          default: r.tk = 1'b0;
        endcase
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic model_ready();
    logic hz;
`ifdef IMM_BRANCH_FLAG_BYPASS_EN
    hz = 1'b0;
`else
    hz = (in_op == 3'b111) && m_valid && m_pay.fw && !out_ready;
`endif
    return !flush && (!m_valid || out_ready) && !hz;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state follows the handshake rules, updated on the same edge as the DUT.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid   <= 1'b0;
      m_pay     <= '0;
      m_flags_q <= 4'h0;
    end else begin
      if (m_valid && out_ready && !flush && m_pay.fw) m_flags_q <= m_pay.fl;
      if (flush) m_valid <= 1'b0;
      else if (in_valid && model_ready()) begin
        m_valid <= 1'b1;
        m_pay   <= mexec(in_op, in_cond, in_pc, in_rb, in_disp,
                         (m_valid && m_pay.fw) ? m_pay.fl : m_flags_q);
      end else if (m_valid && out_ready) m_valid <= 1'b0;
    end
  end

  // Every cycle, compare the DUT against the model on the falling edge.
  always @(negedge clock) begin
    chk("in_ready", {31'h0, in_ready}, {31'h0, model_ready()});
    chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
    chk("flags_q", {28'h0, flags_q}, {28'h0, m_flags_q});
    if (m_valid) begin
      chk("out_result", {16'h0, out_result}, {16'h0, m_pay.res});
      chk("out_flags", {28'h0, out_flags}, {28'h0, m_pay.fl});
      chk("out_rd_we", {31'h0, out_rd_we}, {31'h0, m_pay.rd});
      chk("out_flags_we", {31'h0, out_flags_we}, {31'h0, m_pay.fw});
      chk("out_br_taken", {31'h0, out_br_taken}, {31'h0, m_pay.tk});
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] cond, input logic [15:0] pc,
                       input logic [15:0] rb, input logic [7:0] disp);
    logic got;
    in_valid = 1'b1; in_op = op; in_cond = cond; in_pc = pc; in_rb = rb; in_disp = disp;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock);
      got = in_ready;
      @(posedge clock);
      #1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: op %b not accepted within 20 cycles", op);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic [2:0]  t_op   [8] = '{3'b001, 3'b001, 3'b111, 3'b111, 3'b010, 3'b111, 3'b011, 3'b111};
  logic [2:0]  t_cond [8] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b000, 3'b100, 3'b000, 3'b011};
  logic [15:0] t_pc   [8] = '{16'h0, 16'h0, 16'h0040, 16'h0040, 16'h0, 16'h0, 16'h0, 16'h007F};
  logic [15:0] t_rb   [8] = '{16'hFFFF, 16'h8000, 16'h0, 16'h0, 16'h8000, 16'h0, 16'h1234, 16'h0};
  logic [7:0]  t_disp [8] = '{8'h01, 8'hFF, 8'h10, 8'hF0, 8'h01, 8'h00, 8'h55, 8'h80};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 3'b000; in_cond = 3'b000; in_pc = 16'h0; in_rb = 16'h0; in_disp = 8'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result", {16'h0, out_result}, 32'h0);
    chk("rst_flagsq", {28'h0, flags_q}, 32'h0);
    reset = 1'b0;
    idle(1);

    issue(3'b001, 3'b000, 16'h0, 16'h7FFF, 8'h01); in_valid = 1'b0;
    chk("addi_res", {16'h0, out_result}, 32'h8000);
    chk("addi_flags", {28'h0, out_flags}, 32'hC);
    chk("addi_rdwe", {31'h0, out_rd_we}, 32'h1);
    idle(1);
    chk("addi_flagsq", {28'h0, flags_q}, 32'hC);

    issue(3'b010, 3'b000, 16'h0, 16'h0000, 8'h01); in_valid = 1'b0;
    chk("subi_res", {16'h0, out_result}, 32'hFFFF);
    chk("subi_flags", {28'h0, out_flags}, 32'h9);
    issue(3'b000, 3'b000, 16'h0, 16'h0, 8'h80); in_valid = 1'b0;
    chk("li_res", {16'h0, out_result}, 32'hFF80);
    chk("li_flags", {28'h0, out_flags}, 32'h8);
    issue(3'b100, 3'b000, 16'h0010, 16'h0, 8'hFE); in_valid = 1'b0;
    chk("b_res", {16'h0, out_result}, 32'h000F);
    chk("b_taken", {31'h0, out_br_taken}, 32'h1);
    chk("b_we", {30'h0, out_rd_we, out_flags_we}, 32'h0);
    issue(3'b100, 3'b000, 16'hFFFF, 16'h0, 8'h00); in_valid = 1'b0;
    chk("b_wrap", {16'h0, out_result}, 32'h0000);
    idle(2);

    for (int i = 0; i < 8; i++) issue(t_op[i], t_cond[i], t_pc[i], t_rb[i], t_disp[i]);
    idle(2);

    // SUBI 5-5 stalled in the output, then BE waits for it to drain.
    out_ready = 1'b0;
    issue(3'b010, 3'b000, 16'h0, 16'h0005, 8'h05);
    in_op = 3'b111; in_cond = 3'b000; in_pc = 16'h0020; in_disp = 8'h02;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("stall_rdy", {31'h0, in_ready}, 32'h0);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("stall_release", {31'h0, in_ready}, 32'h1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("be_taken", {31'h0, out_br_taken}, 32'h1);
    chk("be_target", {16'h0, out_result}, 32'h0023);
    chk("be_flagsq", {28'h0, flags_q}, 32'h2);
    idle(2);

    // Flush drops a stalled SUBI, both with and without writeback ready.
    for (int f = 0; f < 2; f++) begin
      out_ready = 1'b0;
      issue(3'b010, 3'b000, 16'h0, 16'h0003, 8'h01);
      in_op = 3'b000;
      out_ready = (f == 1);
      flush = 1'b1;
      @(negedge clock);
      chk("flush_rdy", {31'h0, in_ready}, 32'h0);
      @(posedge clock);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", {31'h0, out_valid}, 32'h0);
      chk("flush_flagsq", {28'h0, flags_q}, 32'h2);
      out_ready = 1'b1;
      idle(2);
    end

    // Reset while an ADDI is stalled.
    out_ready = 1'b0;
    issue(3'b001, 3'b000, 16'h0, 16'h7FFF, 8'h01); in_valid = 1'b0;
    #2 reset = 1'b1;
    @(negedge clock);
    chk("mrst_valid", {31'h0, out_valid}, 32'h0);
    chk("mrst_payload", {9'h0, out_result, out_rd_we, out_flags_we, out_flags, out_br_taken}, 32'h0);
    chk("mrst_flagsq", {28'h0, flags_q}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0; out_ready = 1'b1;
    issue(3'b111, 3'b011, 16'h0100, 16'h0, 8'h04);
    chk("bne_taken", {31'h0, out_br_taken}, 32'h1);
    chk("bne_target", {16'h0, out_result}, 32'h0105);
    issue(3'b111, 3'b000, 16'h0100, 16'h0, 8'h04);
    chk("be_not_taken", {31'h0, out_br_taken}, 32'h0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
